cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Producer side of the CDB: collects completed results (ROB tag + value) from N_FU functional
//  units and broadcasts at most one per cycle as a CDB_PACKET to RS entries, map table and ROB.
//  One holding slot per FU with valid/ready backpressure; round-robin arbitration; squash support.
//  reg_tag==0 means "no broadcast" (tag 0 is reserved for the register file), matching RS_entry.
// PARAMETERS
//  N_FU   4   number of functional-unit completion ports
//  TAG_W  5   ROB tag width (32-entry ROB); tag 0 reserved/invalid
//  XLEN   32  result value width
// PORTS
//  clock           in   1            system clock, all state on posedge
//  reset           in   1            synchronous, active-low reset
//  squash          in   1            branch-mispredict flush, synchronous
//  fu_valid        in   N_FU         FU i presents a completed result
//  fu_tag          in   N_FU*TAG_W   ROB tag of FU i result, slice [i*TAG_W +: TAG_W]
//  fu_value        in   N_FU*XLEN    result value of FU i, slice [i*XLEN +: XLEN]
//  fu_ready        out  N_FU         slot i can accept this cycle (combinational)
//  cdb_packet_out  out  CDB_PACKET   registered broadcast {reg_tag, reg_value}
//  cdb_valid       out  1            registered; 1 iff cdb_packet_out.reg_tag != 0
// BEHAVIOUR
//  - Reset (reset==0 at posedge): hold_valid all 0, rr_ptr=0, cdb_packet_out={0,0}, cdb_valid=0.
//    While reset==0, fu_ready=0. Reset mid-operation discards all pending results.
//  - Handshake: FU i transfers when fu_valid[i] & fu_ready[i] at posedge; value stored in hold[i].
//    fu_ready[i] = reset & ~squash & (~hold_valid[i] | grant[i]).
//  - Same-cycle grant+accept on FU i: old entry broadcast, new entry loaded -> 1 result/cycle/FU.
//  - fu_valid with fu_tag==0: handshake completes, entry discarded (never broadcast).
//  - Arbitration (combinational over hold_valid only): grant = first i in order rr_ptr,
//    rr_ptr+1, ... wrapping mod N_FU with hold_valid[i]. One-hot or zero.
//  - On posedge with a grant g: cdb_packet_out <= hold[g], cdb_valid <= 1, hold_valid[g] cleared
//    unless reloaded, rr_ptr <= (g+1) mod N_FU. No grant: cdb_packet_out <= {0,0}, cdb_valid <= 0,
//    rr_ptr unchanged. Each broadcast lasts exactly one cycle.
//  - Latency: result accepted at posedge k appears on cdb_packet_out after posedge k+1 at the
//    earliest (no input bypass); worst case k+N_FU.
//  - squash==1 at posedge: all hold_valid cleared, inputs that cycle dropped (fu_ready=0),
//    cdb_packet_out <= {0,0}, cdb_valid <= 0; rr_ptr unchanged. Reset has priority over squash.
//  - No result is ever lost or duplicated outside reset/squash; broadcast order per FU is FIFO.
// STRUCTURE
//  - Shared package: CDB_PACKET (reg_tag, reg_value), TAG_W/XLEN constants; add N_FU constant.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr; output one-hot grant[N], grant_idx, any.
//  - Top: hold registers + handshake logic + output register.
// TESTING
//  1. reset=0 for 2 cycles with fu_valid=4'b1111 -> fu_ready=0, cdb tag 0/value 0 throughout;
//     after release fu_ready=4'b1111, no spurious broadcast.
//  2. FU1 tag 5 value 32'hA for one cycle -> cdb {5,32'hA}, cdb_valid=1 exactly one cycle,
//     after the following posedge; then tag 0.
//  3. FUs 0..3 tags 1..4 in same cycle, rr_ptr=0 -> broadcasts 1,2,3,4 on consecutive cycles;
//     fu_ready[i] returns high in the cycle slot i is granted.
//  4. FU0 and FU2 held valid continuously (new tags 6,7,8 / 9,10,11 each accept) -> CDB
//     alternates 6,9,7,10,8,11; full throughput, no tag skipped or repeated.
//  5. Tags 3,4,7 pending in FUs 0,1,3, assert squash one cycle -> next cycle cdb tag 0,
//     no later broadcast of 3/4/7; fu_ready=0 during squash cycle, 1 afterwards.
//  6. FU2 valid with tag 0 value 99 -> fu_ready=1, accepted, never broadcast; cdb_valid stays 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter: packet layout, widths, pointer helper.
package cdb_arbiter_pkg;

  localparam int unsigned N_FU  = 4;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] reg_tag;
    logic [XLEN-1:0]  reg_value;
  } cdb_packet_t;

  // Round-robin pointer advance that wraps correctly for non-power-of-two N_FU.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_FU - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU completion ports plus CDB broadcast, bundled for the arbiter and its producers/consumers.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [N_FU-1:0]       fu_valid;
  logic [N_FU*TAG_W-1:0] fu_tag;
  logic [N_FU*XLEN-1:0]  fu_value;
  logic [N_FU-1:0]       fu_ready;
  cdb_packet_t           cdb_packet_out;
  logic                  cdb_valid;

  modport master (
    output fu_valid, fu_tag, fu_value,
    input  fu_ready, cdb_packet_out, cdb_valid
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value,
    output fu_ready, cdb_packet_out, cdb_valid
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);

  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IdxW'(idx);
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects FU results into one holding slot per FU and broadcasts one per cycle on the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  input logic          squash,
  cdb_arbiter_if.slave bus
);

  cdb_packet_t [N_FU-1:0] hold_q, hold_d;
  logic [N_FU-1:0]        hold_valid_q, hold_valid_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  cdb_packet_t            cdb_q, cdb_d;
  logic                   cdb_valid_q, cdb_valid_d;

  logic [N_FU-1:0]  grant, fu_ready, accept;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;

  rr_arbiter #(
    .N (N_FU)
  ) u_rr_arbiter (
    .req_i       (hold_valid_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // A slot being granted this cycle can take a new result in the same cycle.
  always_comb begin
    fu_ready = {N_FU{reset & ~squash}} & (~hold_valid_q | grant);
    accept   = bus.fu_valid & fu_ready;
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_d        = '0;
    cdb_valid_d  = 1'b0;
    if (grant_any) begin
      cdb_d                   = hold_q[grant_idx];
      cdb_valid_d             = 1'b1;
      hold_valid_d[grant_idx] = 1'b0;
      rr_ptr_d                = ptr_inc(grant_idx);
    end
    // Tag 0 completes the handshake but is never stored.
    for (int unsigned i = 0; i < N_FU; i++) begin
      if (accept[i] && (bus.fu_tag[i*TAG_W +: TAG_W] != '0)) begin
        hold_d[i].reg_tag   = bus.fu_tag[i*TAG_W +: TAG_W];
        hold_d[i].reg_value = bus.fu_value[i*XLEN +: XLEN];
        hold_valid_d[i]     = 1'b1;
      end
    end
    if (squash) begin
      hold_valid_d = '0;
      rr_ptr_d     = rr_ptr_q;
      cdb_d        = '0;
      cdb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q       <= '0;
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_q        <= '0;
      cdb_valid_q  <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
      cdb_valid_q  <= cdb_valid_d;
    end
  end

  assign bus.fu_ready       = fu_ready;
  assign bus.cdb_packet_out = cdb_q;
  assign bus.cdb_valid      = cdb_valid_q;

endmodule
